// File: rtl/counter_pkg.sv
// Shared types and default constants for the up/down counter slice.
// Boundary modes pick what happens when a step runs off either end of 0..MAX.
package counter_pkg;

    typedef enum logic [1:0] {
        CNT_WRAP    = 2'd0,
        CNT_SAT     = 2'd1,
        CNT_ONESHOT = 2'd2
    } cnt_mode_t;

    localparam int CNT_DW   = 8;
    localparam int CNT_MAX  = 7;
    localparam int CNT_INIT = 7;

endpackage

// File: rtl/counter_next.sv
// Combinational next-count logic: one step up or down within 0..MAX.
// Zero latency; flags boundary steps and steps that land on the terminal value.
module counter_next
    import counter_pkg::*;
#(
    parameter int dw  = CNT_DW,
    parameter int MAX = CNT_MAX
) (
    input  logic [dw-1:0] count,
    input  logic          up,
    input  cnt_mode_t     mode,
    output logic [dw-1:0] next,
    output logic          boundary,
    output logic          hit_tc
);

    localparam logic [dw-1:0] MAX_V = dw'(MAX);
    localparam logic [dw-1:0] ONE   = dw'(1);
    localparam logic [dw-1:0] ZERO  = '0;

    always_comb begin
        boundary = up ? (count == MAX_V) : (count == ZERO);
        next     = count;
        hit_tc   = 1'b0;
        if (!boundary) begin
            next   = up ? count + ONE : count - ONE;
            // terminal is MAX going up, 0 going down; wrapping into it does not count
            hit_tc = up ? (count == MAX_V - ONE) : (count == ONE);
        end else if (mode == CNT_WRAP) begin
            next = up ? ZERO : MAX_V;
        end
    end

endmodule

// File: rtl/counter_updown.sv
// Up/down counter over 0..MAX with wrap, saturate or one-shot boundary handling.
// All outputs registered; one-cycle update latency, reset > load > enabled step > hold.
module counter_updown
    import counter_pkg::*;
#(
    parameter int        dw   = CNT_DW,
    parameter int        MAX  = CNT_MAX,
    parameter int        INIT = CNT_INIT,
    parameter cnt_mode_t MODE = CNT_WRAP
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ena,
    input  logic          up,
    input  logic          load,
    input  logic [dw-1:0] load_val,
    output logic [dw-1:0] result,
    output logic          tc,
    output logic          running
);

    localparam logic [dw-1:0] MAX_V  = dw'(MAX);
    localparam logic [dw-1:0] INIT_V = dw'(INIT);

    if (dw < 2 || MAX < 1 || INIT < 0 || INIT > MAX || MAX > (2 ** dw) - 1) begin : g_bad_params
        $error("counter_updown: parameters require dw>=2, 1<=MAX<=2**dw-1, 0<=INIT<=MAX");
    end

    logic [dw-1:0] step_val;
    logic          boundary;
    logic          hit_tc;
    logic [dw-1:0] load_clamped;

    assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

    counter_next #(
        .dw  (dw),
        .MAX (MAX)
    ) u_next (
        .count    (result),
        .up       (up),
        .mode     (MODE),
        .next     (step_val),
        .boundary (boundary),
        .hit_tc   (hit_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            result  <= INIT_V;
            tc      <= 1'b0;
            running <= 1'b1;
        end else if (load) begin
            result  <= load_clamped;
            tc      <= 1'b0;
            running <= 1'b1;
        end else if (ena && running) begin
            result <= step_val;
            tc     <= hit_tc;
            // only a one-shot counter stops; wrap and saturate keep running
            if (MODE == CNT_ONESHOT && boundary) begin
                running <= 1'b0;
            end
        end else begin
            tc <= 1'b0;
        end
    end

endmodule

// File: tb/tb_counter_updown.sv
// Bench for counter_updown: wrap, saturate and one-shot instances on shared stimulus.
// Expectations are queued as stimulus is driven and popped after the clock edge.
module tb_counter_updown;
    import counter_pkg::*;

    typedef struct {
        int         inst;
        logic [7:0] r;
        logic       tc;
        logic       run;
    } exp_t;

    typedef struct {
        int rs, ld, en, u, lv;
        int r, tc, run;
    } step_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0, ena = 1'b0, up = 1'b0, load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic [7:0] res  [3];
    logic       tco  [3];
    logic       runo [3];

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    counter_updown #(.dw(8), .MAX(7), .INIT(7), .MODE(CNT_WRAP)) u_wrap (
        .clk(clk), .reset(reset), .ena(ena), .up(up), .load(load), .load_val(load_val),
        .result(res[0]), .tc(tco[0]), .running(runo[0]));
    counter_updown #(.dw(8), .MAX(7), .INIT(7), .MODE(CNT_SAT)) u_sat (
        .clk(clk), .reset(reset), .ena(ena), .up(up), .load(load), .load_val(load_val),
        .result(res[1]), .tc(tco[1]), .running(runo[1]));
    counter_updown #(.dw(8), .MAX(7), .INIT(7), .MODE(CNT_ONESHOT)) u_one (
        .clk(clk), .reset(reset), .ena(ena), .up(up), .load(load), .load_val(load_val),
        .result(res[2]), .tc(tco[2]), .running(runo[2]));

    task automatic drive(input logic rs, input logic ld, input logic en, input logic u,
                         input logic [7:0] lv);
        reset    = rs;
        load     = ld;
        ena      = en;
        up       = u;
        load_val = lv;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int k = 0; k < 3; k++) sb.push_back('{k, 8'd7, 1'b0, 1'b1});
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if ({res[e.inst], tco[e.inst], runo[e.inst]} !== {e.r, e.tc, e.run}) begin
                n_err++;
                $display("FAIL reset inst %0d: result=%0d tc=%b running=%b, required result=%0d tc=%b running=%b",
                         e.inst, res[e.inst], tco[e.inst], runo[e.inst], e.r, e.tc, e.run);
            end
        end
    endtask

    task automatic test_wrap_up();
        step_t s [8];
        exp_t  e;
        s = '{'{1,0,0,0,0, 7,0,1}, '{0,0,1,1,0, 0,0,1}, '{0,0,1,1,0, 1,0,1},
              '{0,1,0,0,5, 5,0,1}, '{0,0,1,1,0, 6,0,1}, '{0,0,1,1,0, 7,1,1},
              '{0,0,0,1,0, 7,0,1}, '{0,0,1,1,0, 0,0,1}};
        foreach (s[i]) begin
            sb.push_back('{0, 8'(s[i].r), 1'(s[i].tc), 1'(s[i].run)});
            drive(1'(s[i].rs), 1'(s[i].ld), 1'(s[i].en), 1'(s[i].u), 8'(s[i].lv));
            e = sb.pop_front();
            n_cmp++;
            if ({res[e.inst], tco[e.inst], runo[e.inst]} !== {e.r, e.tc, e.run}) begin
                n_err++;
                $display("FAIL wrap_up step %0d: result=%0d tc=%b running=%b, required result=%0d tc=%b running=%b",
                         i, res[e.inst], tco[e.inst], runo[e.inst], e.r, e.tc, e.run);
            end
        end
    endtask

    task automatic test_wrap_down();
        step_t s [11];
        exp_t  e;
        s = '{'{1,0,0,0,0, 7,0,1}, '{0,0,1,0,0, 6,0,1}, '{0,0,1,0,0, 5,0,1},
              '{0,0,1,0,0, 4,0,1}, '{0,0,1,0,0, 3,0,1}, '{0,0,1,0,0, 2,0,1},
              '{0,0,1,0,0, 1,0,1}, '{0,0,1,0,0, 0,1,1}, '{0,0,1,0,0, 7,0,1},
              '{0,0,0,0,0, 7,0,1}, '{0,0,1,1,0, 0,0,1}};
        foreach (s[i]) begin
            sb.push_back('{0, 8'(s[i].r), 1'(s[i].tc), 1'(s[i].run)});
            drive(1'(s[i].rs), 1'(s[i].ld), 1'(s[i].en), 1'(s[i].u), 8'(s[i].lv));
            e = sb.pop_front();
            n_cmp++;
            if ({res[e.inst], tco[e.inst], runo[e.inst]} !== {e.r, e.tc, e.run}) begin
                n_err++;
                $display("FAIL wrap_down step %0d: result=%0d tc=%b running=%b, required result=%0d tc=%b running=%b",
                         i, res[e.inst], tco[e.inst], runo[e.inst], e.r, e.tc, e.run);
            end
        end
    endtask

    task automatic test_sat();
        step_t s [8];
        exp_t  e;
        s = '{'{0,1,0,0,5, 5,0,1}, '{0,0,1,1,0, 6,0,1}, '{0,0,1,1,0, 7,1,1},
              '{0,0,1,1,0, 7,0,1}, '{0,0,1,1,0, 7,0,1}, '{0,0,1,0,0, 6,0,1},
              '{0,1,0,0,0, 0,0,1}, '{0,0,1,0,0, 0,0,1}};
        foreach (s[i]) begin
            sb.push_back('{1, 8'(s[i].r), 1'(s[i].tc), 1'(s[i].run)});
            drive(1'(s[i].rs), 1'(s[i].ld), 1'(s[i].en), 1'(s[i].u), 8'(s[i].lv));
            e = sb.pop_front();
            n_cmp++;
            if ({res[e.inst], tco[e.inst], runo[e.inst]} !== {e.r, e.tc, e.run}) begin
                n_err++;
                $display("FAIL sat step %0d: result=%0d tc=%b running=%b, required result=%0d tc=%b running=%b",
                         i, res[e.inst], tco[e.inst], runo[e.inst], e.r, e.tc, e.run);
            end
        end
    endtask

    task automatic test_oneshot();
        step_t s [8];
        exp_t  e;
        s = '{'{0,1,0,0,2, 2,0,1}, '{0,0,1,0,0, 1,0,1}, '{0,0,1,0,0, 0,1,1},
              '{0,0,1,0,0, 0,0,0}, '{0,0,1,0,0, 0,0,0}, '{0,0,1,1,0, 0,0,0},
              '{0,1,0,0,3, 3,0,1}, '{0,0,1,1,0, 4,0,1}};
        foreach (s[i]) begin
            sb.push_back('{2, 8'(s[i].r), 1'(s[i].tc), 1'(s[i].run)});
            drive(1'(s[i].rs), 1'(s[i].ld), 1'(s[i].en), 1'(s[i].u), 8'(s[i].lv));
            e = sb.pop_front();
            n_cmp++;
            if ({res[e.inst], tco[e.inst], runo[e.inst]} !== {e.r, e.tc, e.run}) begin
                n_err++;
                $display("FAIL oneshot step %0d: result=%0d tc=%b running=%b, required result=%0d tc=%b running=%b",
                         i, res[e.inst], tco[e.inst], runo[e.inst], e.r, e.tc, e.run);
            end
        end
    endtask

    task automatic test_load_clamp();
        step_t s [7];
        exp_t  e;
        s = '{'{0,1,1,1,200, 7,0,1}, '{0,0,1,1,0, 0,0,1}, '{0,1,1,0,3, 3,0,1},
              '{0,1,1,0,7,   7,0,1}, '{0,1,0,0,6, 6,0,1}, '{0,0,1,1,0, 7,1,1},
              '{0,1,1,1,7,   7,0,1}};
        foreach (s[i]) begin
            sb.push_back('{0, 8'(s[i].r), 1'(s[i].tc), 1'(s[i].run)});
            drive(1'(s[i].rs), 1'(s[i].ld), 1'(s[i].en), 1'(s[i].u), 8'(s[i].lv));
            e = sb.pop_front();
            n_cmp++;
            if ({res[e.inst], tco[e.inst], runo[e.inst]} !== {e.r, e.tc, e.run}) begin
                n_err++;
                $display("FAIL load_clamp step %0d: result=%0d tc=%b running=%b, required result=%0d tc=%b running=%b",
                         i, res[e.inst], tco[e.inst], runo[e.inst], e.r, e.tc, e.run);
            end
        end
    endtask

    task automatic test_reset_override();
        step_t s [6];
        exp_t  e;
        s = '{'{0,1,0,0,1, 1,0,1}, '{0,0,1,0,0, 0,1,1}, '{0,0,1,0,0, 0,0,0},
              '{1,1,1,1,3, 7,0,1}, '{0,0,1,1,0, 7,0,0}, '{1,1,1,0,2, 7,0,1}};
        foreach (s[i]) begin
            sb.push_back('{2, 8'(s[i].r), 1'(s[i].tc), 1'(s[i].run)});
            drive(1'(s[i].rs), 1'(s[i].ld), 1'(s[i].en), 1'(s[i].u), 8'(s[i].lv));
            e = sb.pop_front();
            n_cmp++;
            if ({res[e.inst], tco[e.inst], runo[e.inst]} !== {e.r, e.tc, e.run}) begin
                n_err++;
                $display("FAIL reset_override step %0d: result=%0d tc=%b running=%b, required result=%0d tc=%b running=%b",
                         i, res[e.inst], tco[e.inst], runo[e.inst], e.r, e.tc, e.run);
            end
        end
    endtask

    task automatic test_random();
        int         mc [3];
        int         mt [3];
        int         mr [3];
        logic       rs, ld, en, u;
        logic [7:0] lv;
        exp_t       e;
        for (int n = 0; n < 300; n++) begin
            rs = (n == 0) || ($urandom_range(0, 49) == 0);
            ld = ($urandom_range(0, 9) == 0);
            en = ($urandom_range(0, 3) != 0);
            u  = ($urandom_range(0, 2) != 0);
            lv = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7));
            for (int k = 0; k < 3; k++) begin
                if (rs) begin
                    mc[k] = 7; mt[k] = 0; mr[k] = 1;
                end else if (ld) begin
                    mc[k] = (lv > 8'd7) ? 7 : int'(lv); mt[k] = 0; mr[k] = 1;
                end else if (en && mr[k] != 0) begin
                    mt[k] = 0;
                    if (u) begin
                        if (mc[k] < 7) begin mc[k]++; mt[k] = (mc[k] == 7) ? 1 : 0; end
                        else if (k == 0) mc[k] = 0;
                        else if (k == 2) mr[k] = 0;
                    end else begin
                        if (mc[k] > 0) begin mc[k]--; mt[k] = (mc[k] == 0) ? 1 : 0; end
                        else if (k == 0) mc[k] = 7;
                        else if (k == 2) mr[k] = 0;
                    end
                end else begin
                    mt[k] = 0;
                end
                sb.push_back('{k, 8'(mc[k]), 1'(mt[k]), 1'(mr[k])});
            end
            drive(rs, ld, en, u, lv);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if ({res[e.inst], tco[e.inst], runo[e.inst]} !== {e.r, e.tc, e.run}) begin
                    n_err++;
                    $display("FAIL random cycle %0d inst %0d: result=%0d tc=%b running=%b, required result=%0d tc=%b running=%b",
                             n, e.inst, res[e.inst], tco[e.inst], runo[e.inst], e.r, e.tc, e.run);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_sat();
        test_oneshot();
        test_load_clamp();
        test_reset_override();
        test_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/counter_updown.md
COUNTER_UPDOWN -- requirements
Module: counter_updown

Interface
REQ-001 Parameter: dw, default 8, counter width in bits (dw >= 2).
REQ-002 Parameter: MAX, default 7, upper count bound (1 <= MAX <= 2**dw-1); the count range is 0..MAX.
REQ-003 Parameter: INIT, default 7, value of result after reset (INIT <= MAX).
REQ-004 Parameter: MODE, default CNT_WRAP, boundary behaviour, of type cnt_mode_t: CNT_WRAP, CNT_SAT or CNT_ONESHOT.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 ena  input  1  count enable.
REQ-008 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-009 load  input  1  synchronous load strobe.
REQ-010 load_val  input  dw  value to load.
REQ-011 result  output  dw  current count (registered).
REQ-012 tc  output  1  registered one-cycle terminal-count pulse.
REQ-013 running  output  1  registered; 0 only when CNT_ONESHOT has expired.

Function
REQ-014 Priority per edge SHALL be reset > load > (ena && running) > hold.
REQ-015 Load SHALL write min(load_val, MAX) to result, set running=1 and clear tc, regardless of ena or up.
REQ-016 With ena=1, running=1, up=1 and result<MAX, result SHALL become result+1.
REQ-017 With ena=1, running=1, up=0 and result>0, result SHALL become result-1.
REQ-018 Boundary step: an enabled up-step from MAX or down-step from 0.
REQ-019 At a boundary step in CNT_WRAP, result SHALL go to 0 (up) or MAX (down).
REQ-020 At a boundary step in CNT_SAT, result SHALL hold its value.
REQ-021 At a boundary step in CNT_ONESHOT, result SHALL hold and running SHALL clear to 0.
REQ-022 tc SHALL be 1 in the cycle after an edge on which the count stepped into the terminal value: MAX when up=1, 0 when up=0.
REQ-023 tc SHALL be 0 in every other cycle, including after holds, saturated steps and loads.
REQ-024 In CNT_ONESHOT with running=0, ena SHALL be ignored until load or reset.
REQ-025 In CNT_WRAP and CNT_SAT, running SHALL stay 1.
REQ-026 Direction MAY change on any cycle; each step SHALL use the up value sampled on that edge.
REQ-027 Arithmetic SHALL be dw bits wide, with no intermediate overflow outside 0..MAX.
REQ-028 With ena=0 and load=0, result, running and tc SHALL hold (tc falls to 0 after its pulse).

Reset
REQ-029 On reset=1 at a clock edge: result=INIT, tc=0, running=1.
REQ-030 Reset SHALL override a simultaneous load or ena, and SHALL take effect mid-count and mid-oneshot.
REQ-031 No asynchronous reset path SHALL exist.

Structure
REQ-032 Package counter_pkg SHALL hold the typedef cnt_mode_t (enum CNT_WRAP, CNT_SAT, CNT_ONESHOT).
REQ-033 counter_pkg SHALL hold the default constants CNT_DW=8, CNT_MAX=7 and CNT_INIT=7.
REQ-034 Next-value logic SHALL be one combinational sub-module, counter_next, with inputs count, up and mode and outputs next, boundary and hit_tc.
REQ-035 counter_updown SHALL contain only the registers and the priority logic.
REQ-036 An elaboration check SHALL reject INIT > MAX or MAX > 2**dw-1.

Verification
REQ-037 WRAP, MAX=7, reset, then up=1, ena=1 for 2 cycles -> result 7→0→1; tc=1 only in the cycle where result=0... no: tc=1 only in the cycle after the step into MAX; the step 7→0 leaves tc=0.
REQ-038 WRAP, INIT=7, up=0, ena=1 for 8 cycles -> result 6,5,...,0, then 7; tc pulses once, the cycle result=0.
REQ-039 SAT, load_val=5, then up=1 for 4 cycles -> result 6,7,7,7; tc pulses once, at 7.
REQ-040 ONESHOT, load_val=2, up=0, ena=1 for 4 cycles -> result 1,0,0,0; running=0 after the third step; a further load_val=3 gives result=3 and running=1.
REQ-041 load_val=200 with MAX=7 -> result=7; load and ena on the same edge -> load wins.
REQ-042 reset=1 together with load=1 and ena=1 mid-count -> next cycle result=INIT, tc=0, running=1.
